// File: rtl/tl_sensor_cond.sv
// rtl/tl_sensor_cond.sv - vehicle-detector conditioner (sync, on/off qualify, stuck detect); optional counters via TL_SENSOR_CNT_EN

module tl_sensor_chan #(
    parameter int ON_CYC    = 3,
    parameter int OFF_CYC   = 4,
    parameter int STUCK_CYC = 1000,
    parameter int CNT_W     = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic t_o,
    output logic fault_o,
    output logic rise_o
);
    typedef enum logic [1:0] {IDLE, QUAL_ON, ACTIVE, QUAL_OFF} state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ON_L    = CNT_W'(ON_CYC);
    localparam logic [CNT_W-1:0] OFF_L   = CNT_W'(OFF_CYC);
    localparam logic [CNT_W-1:0] STUCK_L = CNT_W'(STUCK_CYC);

    logic             sync1_q, s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] qcnt_q, qcnt_d, hcnt_q, hcnt_d, qnext;
    logic             fault_q, fault_d, t_q, t_d;

    // Two-flop synchronizer, then state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            state_q <= IDLE;
            qcnt_q  <= '0;
            hcnt_q  <= '0;
            fault_q <= 1'b0;
            t_q     <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            s_q     <= sync1_q;
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            hcnt_q  <= hcnt_d;
            fault_q <= fault_d;
            t_q     <= t_d;
        end
    end

    // Qualification FSM, stuck-high counter and the forced-on output decode
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        qnext   = qcnt_q + ONE;
        case (state_q)
            IDLE: begin
                if (s_q) begin
                    if (ON_CYC == 1) begin
                        state_d = ACTIVE;
                        qcnt_d  = '0;
                    end else begin
                        state_d = QUAL_ON;
                        qcnt_d  = ONE;
                    end
                end
            end
            QUAL_ON: begin
                if (!s_q) begin
                    state_d = IDLE;
                    qcnt_d  = '0;
                end else if (qnext == ON_L) begin
                    state_d = ACTIVE;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d  = qnext;
                end
            end
            ACTIVE: begin
                if (!s_q) begin
                    if (OFF_CYC == 1) begin
                        state_d = IDLE;
                        qcnt_d  = '0;
                    end else begin
                        state_d = QUAL_OFF;
                        qcnt_d  = ONE;
                    end
                end
            end
            QUAL_OFF: begin
                if (s_q) begin
                    state_d = ACTIVE;
                    qcnt_d  = '0;
                end else if (qnext == OFF_L) begin
                    state_d = IDLE;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d  = qnext;
                end
            end
            default: begin
                state_d = IDLE;
                qcnt_d  = '0;
            end
        endcase

        if (!s_q) begin
            hcnt_d = '0;
        end else if (hcnt_q == STUCK_L) begin
            hcnt_d = hcnt_q;
        end else begin
            hcnt_d = hcnt_q + ONE;
        end

        fault_d = fault_q | (hcnt_d == STUCK_L);
        t_d     = fault_d | (state_d == ACTIVE) | (state_d == QUAL_OFF);
        rise_o  = (state_d == ACTIVE) & ((state_q == IDLE) | (state_q == QUAL_ON));
    end

    assign t_o     = t_q;
    assign fault_o = fault_q;
endmodule

module tl_sensor_cond #(
    parameter int ON_CYC    = 3,
    parameter int OFF_CYC   = 4,
    parameter int STUCK_CYC = 1000,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_a,
    input  logic       raw_b,
    output logic       Ta,
    output logic       Tb,
    output logic       fault_a,
    output logic       fault_b
`ifdef TL_SENSOR_CNT_EN
    ,
    input  logic       cnt_clr,
    output logic [7:0] veh_cnt_a,
    output logic [7:0] veh_cnt_b
`endif
);
    logic rise_a, rise_b;

    tl_sensor_chan #(.ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC), .STUCK_CYC(STUCK_CYC), .CNT_W(CNT_W)) u_chan_a (
        .clk(clk), .reset(reset), .raw_i(raw_a), .t_o(Ta), .fault_o(fault_a), .rise_o(rise_a)
    );

    tl_sensor_chan #(.ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC), .STUCK_CYC(STUCK_CYC), .CNT_W(CNT_W)) u_chan_b (
        .clk(clk), .reset(reset), .raw_i(raw_b), .t_o(Tb), .fault_o(fault_b), .rise_o(rise_b)
    );

`ifdef TL_SENSOR_CNT_EN
    logic [7:0] veh_a_q, veh_b_q;

    // Saturating qualified-arrival counters; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            veh_a_q <= 8'd0;
            veh_b_q <= 8'd0;
        end else begin
            if (rise_a && veh_a_q != 8'hFF) veh_a_q <= veh_a_q + 8'd1;
            if (rise_b && veh_b_q != 8'hFF) veh_b_q <= veh_b_q + 8'd1;
        end
    end

    assign veh_cnt_a = veh_a_q;
    assign veh_cnt_b = veh_b_q;
`else
    logic unused_rise;
    assign unused_rise = rise_a ^ rise_b;
`endif
endmodule

// File: doc/tl_sensor_cond.md
Name: tl_sensor_cond

Overview:
- Upstream conditioner for the traffic-light controller. Takes raw, asynchronous, bouncy vehicle-detector loop signals for street A and street B.
- Produces clean, registered occupancy flags Ta/Tb. These wire directly to the controller's Ta/Tb inputs.
- Per channel: 2-flop synchronizer, on/off qualification FSM, stuck-sensor fault detector.

Parameters:
- ON_CYC, 3: consecutive synchronized-high samples needed to assert T (>=1).
- OFF_CYC, 4: consecutive synchronized-low samples needed to deassert T (>=1).
- STUCK_CYC, 1000: consecutive synchronized-high samples that declare a stuck sensor (> ON_CYC).
- CNT_W, 10: width of the per-channel counters. Must satisfy 2^CNT_W-1 >= STUCK_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- raw_a  in  1  asynchronous detector loop, street A (1 = vehicle).
- raw_b  in  1  asynchronous detector loop, street B.
- Ta  out  1  qualified traffic present on A, registered.
- Tb  out  1  qualified traffic present on B, registered.
- fault_a  out  1  sticky stuck-high flag, street A.
- fault_b  out  1  sticky stuck-high flag, street B.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; sampled only on the clk rising edge.
- Reset values: Ta=0, Tb=0, fault_a=0, fault_b=0. Sync flops=0, FSMs=IDLE, all counters=0. Reset mid-operation overrides every other event in that cycle.
- Channels A and B are identical and fully independent. Channel A is described below; s = second synchronizer flop.
- FSM states and T value:
  - IDLE (T=0): s=1 -> QUAL_ON with qcnt=1. If ON_CYC=1, go straight to ACTIVE.
  - QUAL_ON (T=0): s=0 -> IDLE, qcnt=0. Else qcnt+1; when qcnt+1 reaches ON_CYC -> ACTIVE.
  - ACTIVE (T=1): s=0 -> QUAL_OFF with qcnt=1. If OFF_CYC=1, go straight to IDLE.
  - QUAL_OFF (T=1): s=1 -> ACTIVE, qcnt=0. Else qcnt+1; when qcnt+1 reaches OFF_CYC -> IDLE.
- T is a registered decode of state, with no combinational path from raw.
- Latency: raw rising, stable, first captured at edge 1 -> T=1 after edge ON_CYC+2. Falling is symmetric: T=0 after edge OFF_CYC+2.
- Glitch rejection: a raw pulse shorter than ON_CYC cycles never asserts T. A raw gap shorter than OFF_CYC cycles never deasserts T.
- Stuck detector:
  - hcnt counts consecutive s=1 samples, saturating at STUCK_CYC; any s=0 clears it.
  - When hcnt reaches STUCK_CYC, fault=1 on that edge.
  - fault is sticky: cleared only by reset.
  - While fault=1, T is forced to 1 (fail-safe: the controller keeps serving that street). The FSM keeps running underneath.
- Simultaneous events: A and B asserting in the same cycle produce Ta and Tb on the same edge. There is no arbitration here; arbitration belongs to the controller.

Optional Feature:
- Macro: TL_SENSOR_CNT_EN.
- Defined: adds the following ports.
  - cnt_clr  in  1: synchronous clear.
  - veh_cnt_a  out  8: vehicle count, street A.
  - veh_cnt_b  out  8: vehicle count, street B.
- Counting rules:
  - Each count increments on every IDLE/QUAL_ON -> ACTIVE transition, i.e. each T rising edge not caused by a fault force.
  - Counts saturate at 255.
  - Reset or cnt_clr -> 0. cnt_clr wins over a same-cycle increment.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset held 3 cycles with raw_a=raw_b=1 -> Ta=Tb=0, fault_a=fault_b=0 throughout reset.
- Defaults; raw_a 0->1 held 10 cycles -> Ta rises after edge 5 from first capture. raw_a->0 -> Ta falls after edge 6 from first low capture.
- raw_b high for 2 cycles then low -> Tb stays 0. With Ta=1, raw_a low for 3 cycles then high -> Ta never drops.
- raw_a and raw_b rise in the same cycle -> Ta and Tb assert on the same edge. Later release of B only -> Ta unaffected.
- STUCK_CYC=20; raw_a held high 25 cycles then low -> fault_a=1 at hcnt=20. Ta remains 1 after release, until reset clears both.
- TL_SENSOR_CNT_EN: 3 qualified A pulses -> veh_cnt_a=3. cnt_clr pulsed on the same edge as a 4th qualification -> veh_cnt_a=0. 300 B pulses -> veh_cnt_b=255.
